hash_serializer: RTL and testbench
==================================

# hash_serializer

Output stage directly downstream of the transaction validator pipeline. Accepts 128-bit validated hashes as single-cycle `i_valid` pulses, with no backpressure available upstream. Buffers them in a small circular FIFO and emits each hash as four 32-bit beats on a valid/ready stream toward the host link. Hashes arriving while the buffer is full are dropped and counted.

## Interface
- `DEPTH`, default 4: hash entries buffered. Must be a power of 2 and ≥ 2; pointers wrap naturally.
- `CNT_W`, default 16: width of the drop counter.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: reset, synchronous, active-low (0 = reset).
- `i_valid`, in, 1: hash present on `i_hash` this cycle; no ready returned.
- `i_hash`, in, 128: validated hash.
- `o_valid`, out, 1: `o_data` holds a valid beat.
- `o_data`, out, 32: current beat; 0 when `o_valid` = 0.
- `o_last`, out, 1: current beat is beat 3 of a hash; 0 when `o_valid` = 0.
- `o_ready`, in, 1: consumer accepts the beat.
- `o_count`, out, $clog2(DEPTH)+1: entries currently buffered, counting a partially sent head entry.
- `o_drop_cnt`, out, CNT_W: hashes dropped since reset; saturates at all-ones.

## Operation
- **Storage:** `DEPTH` × 128-bit array, write pointer `wp`, read pointer `rp`, occupancy `count` (0..DEPTH), beat index `beat` (0..3).
- **Beat order:** MSW first.
  - beat 0 = `i_hash[127:96]`
  - beat 1 = `[95:64]`
  - beat 2 = `[63:32]`
  - beat 3 = `[31:0]`
- **Transfer:** a transfer occurs when `o_valid & o_ready`.
  - On a transfer, `beat` increments.
  - On a transfer with `beat` = 3: the head entry is popped, `rp` increments mod DEPTH, and `beat` returns to 0.
- **Output signals:**
  - `o_valid` = (`count` != 0).
  - `o_data` = `mem[rp]` slice selected by `beat`.
  - `o_last` = `o_valid & (beat == 3)`.
  - All are combinational from registers only; no combinational path from `i_*` or `o_ready` to outputs.
- **Write acceptance:** an `i_valid` hash is written at `mem[wp]` and `wp` increments if either:
  - `count` < DEPTH, or
  - `count` == DEPTH and a beat-3 transfer occurs in the same cycle (simultaneous pop frees the slot).
- **Drop:** otherwise the hash is dropped and `o_drop_cnt` increments unless it is already all-ones.
- **Occupancy update:**
  - `count` +1 on write without pop.
  - `count` −1 on pop without write.
  - `count` unchanged on both or neither.
- **Stability:** while `o_valid` = 1 and `o_ready` = 0, `o_data` and `o_last` are held stable. A write to another slot never disturbs the head entry.
- **Head-entry protection:** a partially sent head entry is never overwritten. A write only targets `wp`, which equals `rp` only when `count` is 0, or when `count` is DEPTH and the head is popping that cycle.
- **Reset (`rst` = 0 at a clock edge):**
  - `wp`, `rp`, `count`, `beat` and `o_drop_cnt` are cleared to 0.
  - Consequently `o_valid` = 0, `o_data` = 0, `o_last` = 0, `o_count` = 0 from the following cycle.
  - Reset mid-hash discards the partial hash and all buffered entries.
  - An `i_valid` asserted in a reset cycle is ignored and not counted as dropped.
  - Memory contents need no reset.

## Timing
- Latency: a hash accepted at edge N, into an empty buffer with `o_ready` = 1, presents beat 0 in cycle N+1. Its beats transfer on edges N+1..N+4, and it is popped at edge N+4.
- Throughput: one beat per cycle, i.e. one hash per 4 cycles sustained. There are no bubbles between back-to-back hashes.
- `o_ready` may toggle arbitrarily. `o_valid` never deasserts without a beat-3 transfer emptying the buffer.
- `o_count` and `o_drop_cnt` are registered and reflect the edge that caused the change.

## Test plan
- **Single hash:** after reset, `i_hash` = 0x00112233_44556677_8899AABB_CCDDEEFF, one-cycle `i_valid`, `o_ready` = 1.
  - Required: beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on cycles 1–4.
  - Required: `o_last` only on the 4th beat; `o_count` returns to 0.
- **Backpressure:** same hash with `o_ready` = 0 for 5 cycles after beat 1 appears.
  - Required: `o_data` held at 0x44556677, `o_valid` held at 1, then sequence completes unchanged.
- **Overflow:** `o_ready` = 0, 6 consecutive `i_valid` hashes H0..H5 with DEPTH = 4.
  - Required: `o_count` = 4 and `o_drop_cnt` = 2.
  - Required: releasing `o_ready` outputs H0..H3 in order, 16 beats, no H4/H5.
- **Simultaneous pop and write at full:** buffer full, head on beat 3 with `o_ready` = 1, `i_valid` with H4 the same cycle.
  - Required: H4 accepted, `o_count` stays 4, `o_drop_cnt` unchanged.
- **Wrap-around:** stream 10 hashes spaced 4 cycles apart with `o_ready` = 1.
  - Required: all 40 beats in order and `o_drop_cnt` = 0; pointers wrap twice.
- **Reset mid-operation:** 3 buffered hashes, `rst` = 0 for one cycle while beat 2 of the head is presented.
  - Required: next cycle `o_valid` = 0, `o_count` = 0, `o_drop_cnt` = 0.
  - Required: a new hash afterwards starts at beat 0.

Source files
------------

// File: rtl/hash_serializer.sv
// Buffers 128-bit hashes in a small circular FIFO and streams each one out
// as four 32-bit beats, most significant word first.
module hash_serializer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [127:0]            i_hash,
  output logic                    o_valid,
  output logic [31:0]             o_data,
  output logic                    o_last,
  input  logic                    o_ready,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [CNT_W-1:0]        o_drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [127:0]     mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW:0]      count;
  logic [1:0]       beat;
  logic [CNT_W-1:0] drop_cnt;

  logic             xfer;
  logic             pop;
  logic             wr;
  logic             drop;
  logic [127:0]     head;
  logic [31:0]      slice;

  assign head = mem[rp];

  always_comb begin
    slice = 32'd0;
    case (beat)
      2'd0: slice = head[127:96];
      2'd1: slice = head[95:64];
      2'd2: slice = head[63:32];
      2'd3: slice = head[31:0];
      default: slice = 32'd0;
    endcase
  end

  // Outputs depend on registered state only; the data word is forced to zero
  // when nothing is buffered so stale memory never leaks onto the link.
  assign o_valid    = (count != '0);
  assign o_data     = o_valid ? slice : 32'd0;
  assign o_last     = o_valid & (beat == 2'd3);
  assign o_count    = count;
  assign o_drop_cnt = drop_cnt;

  assign xfer = o_valid & o_ready;
  assign pop  = xfer & (beat == 2'd3);
  // A full buffer still accepts when the head is leaving this same cycle.
  assign wr   = i_valid & ((count != FULL) | pop);
  assign drop = i_valid & ~wr;

  always_ff @(posedge clk) begin
    if (rst && wr) begin
      mem[wp] <= i_hash;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      beat     <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr) begin
        wp <= wp + PW'(1);
      end
      if (xfer) begin
        beat <= beat + 2'd1;
      end
      if (pop) begin
        rp <= rp + PW'(1);
      end
      case ({wr, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hash_serializer.sv
// Directed scoreboard bench for hash_serializer: expected beats are queued
// when a hash is offered and checked as the stream hands them over.
module tb_hash_serializer;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic [127:0] i_hash;
  logic         o_valid;
  logic [31:0]  o_data;
  logic         o_last;
  logic         o_ready;
  logic [2:0]   o_count;
  logic [15:0]  o_drop_cnt;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t sb[$];

  hash_serializer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_hash     (i_hash),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_last     (o_last),
    .o_ready    (o_ready),
    .o_count    (o_count),
    .o_drop_cnt (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int i);
    logic [7:0] t;
    t = 8'(i);
    return {t, 24'h0A0A0A, t, 24'h1B1B1B, t, 24'h2C2C2C, t, 24'h3D3D3D};
  endfunction

  task automatic push_exp(input logic [127:0] h);
    beat_t b;
    b.d = h[127:96]; b.l = 1'b0; sb.push_back(b);
    b.d = h[95:64];  b.l = 1'b0; sb.push_back(b);
    b.d = h[63:32];  b.l = 1'b0; sb.push_back(b);
    b.d = h[31:0];   b.l = 1'b1; sb.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] h);
    i_valid = 1'b1;
    i_hash  = h;
    tick();
    i_valid = 1'b0;
    i_hash  = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    chk({tag, "_count0"}, 64'(o_count), 64'd0);
    chk({tag, "_valid0"}, 64'(o_valid), 64'd0);
  endtask

  // Scoreboard side: a beat is handed over at the next edge when valid and
  // ready are both high at the falling edge before it.
  always @(negedge clk) begin
    beat_t e;
    if (rst && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {32'd0, o_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("beat_data", 64'(o_data), 64'(e.d));
        chk("beat_last", 64'(o_last), 64'(e.l));
      end
    end
    if (rst && !o_valid) begin
      chk("idle_data", 64'(o_data), 64'd0);
      chk("idle_last", 64'(o_last), 64'd0);
    end
  end

  initial begin
    logic [127:0] h;
    logic [127:0] h4;
    tests   = 0;
    fails   = 0;
    rst     = 1'b0;
    i_valid = 1'b0;
    i_hash  = '0;
    o_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_drop", 64'(o_drop_cnt), 64'd0);

    // Single hash, ready held high.
    h = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    o_ready = 1'b1;
    push_exp(h);
    send(h);
    chk("single_lat_valid", 64'(o_valid), 64'd1);
    chk("single_lat_data", 64'(o_data), 64'h00112233);
    chk("single_lat_count", 64'(o_count), 64'd1);
    tick(); tick(); tick();
    chk("single_beat3_last", 64'(o_last), 64'd1);
    tick();
    chk("single_done_valid", 64'(o_valid), 64'd0);
    drain("single");

    // Backpressure on beat 1.
    push_exp(h);
    send(h);
    tick();
    o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", 64'(o_data), 64'h44556677);
      chk("bp_valid", 64'(o_valid), 64'd1);
      chk("bp_last", 64'(o_last), 64'd0);
    end
    o_ready = 1'b1;
    drain("bp");

    // Wrap-around: ten hashes back to back, no drops expected.
    for (int i = 0; i < 10; i++) begin
      push_exp(mk(16 + i));
      send(mk(16 + i));
      chk("wrap_count", 64'(o_count), 64'd1);
      tick(); tick(); tick();
    end
    drain("wrap");
    chk("wrap_drop", 64'(o_drop_cnt), 64'd0);

    // Overflow: six hashes into a four-deep buffer with the link stalled.
    o_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) push_exp(mk(32 + i));
      send(mk(32 + i));
    end
    chk("ovf_count", 64'(o_count), 64'd4);
    chk("ovf_drop", 64'(o_drop_cnt), 64'd2);
    o_ready = 1'b1;
    drain("ovf");
    chk("ovf_drop_after", 64'(o_drop_cnt), 64'd2);

    // Full buffer, write arrives in the same cycle the head pops.
    o_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp(mk(48 + i));
      send(mk(48 + i));
    end
    chk("simul_full", 64'(o_count), 64'd4);
    o_ready = 1'b1;
    tick(); tick(); tick();
    chk("simul_head_last", 64'(o_last), 64'd1);
    h4 = mk(52);
    push_exp(h4);
    send(h4);
    chk("simul_count", 64'(o_count), 64'd4);
    chk("simul_drop", 64'(o_drop_cnt), 64'd2);
    drain("simul");

    // Reset while beat 2 of the head is presented; a hash offered during
    // reset must be ignored.
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(mk(64 + i));
      send(mk(64 + i));
    end
    o_ready = 1'b1;
    tick(); tick();
    o_ready = 1'b0;
    chk("mid_beat2", 64'(o_data), 64'(mk(64) >> 32) & 64'hFFFF_FFFF);
    rst     = 1'b0;
    i_valid = 1'b1;
    i_hash  = mk(99);
    tick();
    rst     = 1'b1;
    i_valid = 1'b0;
    sb.delete();
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_count", 64'(o_count), 64'd0);
    chk("mid_rst_drop", 64'(o_drop_cnt), 64'd0);
    chk("mid_rst_data", 64'(o_data), 64'd0);
    o_ready = 1'b1;
    push_exp(mk(80));
    send(mk(80));
    chk("post_rst_beat0", 64'(o_data), 64'(mk(80) >> 96));
    chk("post_rst_last", 64'(o_last), 64'd0);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
